mips32_pipe_fwd: RTL and testbench



---
 rtl/mips32_pipe_fwd.sv | 198 +++++++++++++++++++
 tb/tb_mips32_pipe_fwd.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_pipe_fwd.sv
// Five-stage in-order MIPS32-style core with EX/MEM and MEM/WB forwarding, load-use interlock,
// EX-stage branch flush, a host load/debug port and a retired-instruction counter.
module mips32_pipe_fwd #(
  parameter int XLEN      = 32,
  parameter int MEM_DEPTH = 1024,
  parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic                                 ld_we,
  input  logic [ADDR_W-1:0]                    ld_addr,
  // Memory words are never narrower than one instruction, so narrow-XLEN builds can still be loaded.
  input  logic [((XLEN > 32) ? XLEN : 32)-1:0] ld_data,
  input  logic [4:0]                           dbg_raddr,
  output logic [XLEN-1:0]                      dbg_rdata,
  output logic                                 busy,
  output logic                                 halted,
  output logic [31:0]                          retired
);
  localparam int MW = (XLEN > 32) ? XLEN : 32;

  localparam logic [5:0] OP_ADD  = 6'b000000, OP_SUB  = 6'b000001, OP_AND   = 6'b000010,
                         OP_OR   = 6'b000011, OP_SLT  = 6'b000100, OP_MUL   = 6'b000101,
                         OP_LW   = 6'b001000, OP_SW   = 6'b001001, OP_ADDI  = 6'b001010,
                         OP_SUBI = 6'b001011, OP_SLTI = 6'b001100, OP_BNEQZ = 6'b001101,
                         OP_BEQZ = 6'b001110;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;
  state_t state, state_nxt;

  logic [MW-1:0]   mem [MEM_DEPTH];
  logic [XLEN-1:0] rf  [32];

  logic [ADDR_W-1:0] pc, ifid_npc, idex_npc;
  logic              fetch_on, ifid_vld;
  logic [31:0]       ifid_ir;
  logic              idex_vld, idex_wr, idex_lw, idex_sw, idex_hlt;
  logic [5:0]        idex_op;
  logic [4:0]        idex_rs, idex_rt, idex_dst;
  logic [XLEN-1:0]   idex_a, idex_b, idex_imm;
  logic              exmem_vld, exmem_wr, exmem_lw, exmem_sw, exmem_hlt;
  logic [4:0]        exmem_dst;
  logic [XLEN-1:0]   exmem_alu, exmem_b;
  logic              memwb_vld, memwb_wr, memwb_hlt;
  logic [4:0]        memwb_dst;
  logic [XLEN-1:0]   memwb_val;

  logic run, go, wb_we;
  assign run    = (state == S_RUN);
  assign go     = !run && start;
  assign busy   = run;
  assign halted = (state == S_HALT);
  assign wb_we  = run && memwb_vld && memwb_wr && (memwb_dst != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (memwb_vld && memwb_hlt) state_nxt = S_HALT;
      S_HALT:  if (start) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Decode
  logic [5:0]      id_op;
  logic [4:0]      id_rs, id_rt, id_dst;
  logic [XLEN-1:0] id_imm, id_a, id_b;
  logic            id_r, id_i, id_lw, id_sw, id_br, id_hlt, id_wr, id_use_rt, stall;

  always_comb begin
    id_op      = ifid_ir[31:26];
    id_rs      = ifid_ir[25:21];
    id_rt      = ifid_ir[20:16];
    id_imm     = {XLEN{ifid_ir[15]}};
    id_imm[15:0] = ifid_ir[15:0];
    id_r       = (id_op <= OP_MUL);
    id_i       = (id_op == OP_ADDI) || (id_op == OP_SUBI) || (id_op == OP_SLTI);
    id_lw      = (id_op == OP_LW);
    id_sw      = (id_op == OP_SW);
    id_br      = (id_op == OP_BNEQZ) || (id_op == OP_BEQZ);
    id_hlt     = !(id_r || id_i || id_lw || id_sw || id_br);
    id_wr      = id_r || id_i || id_lw;
    id_dst     = id_r ? ifid_ir[15:11] : id_rt;
    id_use_rt  = id_r || id_sw;
    id_a       = (wb_we && memwb_dst == id_rs) ? memwb_val : rf[id_rs];
    id_b       = (wb_we && memwb_dst == id_rt) ? memwb_val : rf[id_rt];
    stall      = ifid_vld && idex_vld && idex_lw && (idex_dst != 5'd0) &&
                 ((!id_hlt && idex_dst == id_rs) || (id_use_rt && idex_dst == id_rt));
  end

  // Execute: a load still in EX/MEM has no data yet, so it is never a bypass source
  logic [XLEN-1:0]   ex_a, ex_b, ex_alu;
  logic [ADDR_W-1:0] ex_target;
  logic              taken, exmem_fwd, memwb_fwd;

  always_comb begin
    exmem_fwd = exmem_vld && exmem_wr && !exmem_lw && (exmem_dst != 5'd0);
    memwb_fwd = memwb_vld && memwb_wr && (memwb_dst != 5'd0);
    ex_a = idex_a;
    if (exmem_fwd && exmem_dst == idex_rs)      ex_a = exmem_alu;
    else if (memwb_fwd && memwb_dst == idex_rs) ex_a = memwb_val;
    ex_b = idex_b;
    if (exmem_fwd && exmem_dst == idex_rt)      ex_b = exmem_alu;
    else if (memwb_fwd && memwb_dst == idex_rt) ex_b = memwb_val;
    case (idex_op)
      OP_ADD:                 ex_alu = ex_a + ex_b;
      OP_SUB:                 ex_alu = ex_a - ex_b;
      OP_AND:                 ex_alu = ex_a & ex_b;
      OP_OR:                  ex_alu = ex_a | ex_b;
      OP_SLT:                 ex_alu = {{(XLEN-1){1'b0}}, $signed(ex_a) < $signed(ex_b)};
      OP_MUL:                 ex_alu = ex_a * ex_b;
      OP_ADDI, OP_LW, OP_SW:  ex_alu = ex_a + idex_imm;
      OP_SUBI:                ex_alu = ex_a - idex_imm;
      OP_SLTI:                ex_alu = {{(XLEN-1){1'b0}}, $signed(ex_a) < $signed(idex_imm)};
      default:                ex_alu = '0;
    endcase
    taken     = idex_vld && (((idex_op == OP_BEQZ) && (ex_a == '0)) ||
                             ((idex_op == OP_BNEQZ) && (ex_a != '0)));
    ex_target = idex_npc + idex_imm[ADDR_W-1:0];
  end

  // Memory access
  logic [MW-1:0]   fetch_word, mem_word, st_word;
  logic [XLEN-1:0] mem_val;

  always_comb begin
    fetch_word = mem[pc];
    mem_word   = mem[exmem_alu[ADDR_W-1:0]];
    mem_val    = exmem_lw ? mem_word[XLEN-1:0] : exmem_alu;
    st_word    = '0;
    st_word[XLEN-1:0] = exmem_b;
  end

  always_ff @(posedge clk) begin
    if (!run && ld_we)                      mem[ld_addr] <= ld_data;
    else if (run && exmem_vld && exmem_sw)  mem[exmem_alu[ADDR_W-1:0]] <= st_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_we) begin
      rf[memwb_dst] <= memwb_val;
    end
  end

  assign dbg_rdata = (dbg_raddr == 5'd0) ? '0 : rf[dbg_raddr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0; fetch_on <= 1'b0; retired <= '0;
      ifid_vld <= 1'b0; ifid_ir <= '0; ifid_npc <= '0;
      idex_vld <= 1'b0; idex_wr <= 1'b0; idex_lw <= 1'b0; idex_sw <= 1'b0; idex_hlt <= 1'b0;
      idex_op <= '0; idex_rs <= '0; idex_rt <= '0; idex_dst <= '0;
      idex_a <= '0; idex_b <= '0; idex_imm <= '0; idex_npc <= '0;
      exmem_vld <= 1'b0; exmem_wr <= 1'b0; exmem_lw <= 1'b0; exmem_sw <= 1'b0; exmem_hlt <= 1'b0;
      exmem_dst <= '0; exmem_alu <= '0; exmem_b <= '0;
      memwb_vld <= 1'b0; memwb_wr <= 1'b0; memwb_hlt <= 1'b0; memwb_dst <= '0; memwb_val <= '0;
    end else if (go) begin
      pc <= '0; fetch_on <= 1'b1; retired <= '0;
      ifid_vld <= 1'b0; idex_vld <= 1'b0; exmem_vld <= 1'b0; memwb_vld <= 1'b0;
    end else if (run) begin
      if (memwb_vld && !memwb_hlt) retired <= retired + 32'd1;
      memwb_vld <= exmem_vld; memwb_wr <= exmem_wr; memwb_hlt <= exmem_hlt;
      memwb_dst <= exmem_dst; memwb_val <= mem_val;
      exmem_vld <= idex_vld; exmem_wr <= idex_wr; exmem_lw <= idex_lw; exmem_sw <= idex_sw;
      exmem_hlt <= idex_hlt; exmem_dst <= idex_dst; exmem_alu <= ex_alu; exmem_b <= ex_b;
      idex_vld <= ifid_vld && !taken && !stall;
      idex_wr <= id_wr; idex_lw <= id_lw; idex_sw <= id_sw; idex_hlt <= id_hlt;
      idex_op <= id_op; idex_rs <= id_rs; idex_rt <= id_rt; idex_dst <= id_dst;
      idex_a <= id_a; idex_b <= id_b; idex_imm <= id_imm; idex_npc <= ifid_npc;
      // Flush beats stall; a decoded HLT shuts fetch off for the rest of the run
      if (taken) begin
        ifid_vld <= 1'b0;
        pc       <= ex_target;
      end else if (stall) begin
        ifid_vld <= ifid_vld;
      end else if (ifid_vld && id_hlt) begin
        ifid_vld <= 1'b0;
        fetch_on <= 1'b0;
      end else if (fetch_on) begin
        ifid_vld <= 1'b1;
        ifid_ir  <= fetch_word[31:0];
        ifid_npc <= pc + ADDR_W'(1);
        pc       <= pc + ADDR_W'(1);
      end else begin
        ifid_vld <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mips32_pipe_fwd.sv
// Directed bench for mips32_pipe_fwd: register-result table plus hand-written run/reset/control sequences.
module tb_mips32_pipe_fwd;
  localparam logic [5:0] OP_ADD = 6'b000000, OP_MUL = 6'b000101, OP_LW = 6'b001000,
                         OP_SW = 6'b001001, OP_ADDI = 6'b001010, OP_SUBI = 6'b001011,
                         OP_SLTI = 6'b001100, OP_BNEQZ = 6'b001101, OP_HLT = 6'b111111;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start = 1'b0, ld_we = 1'b0;
  logic [9:0]  ld_addr = '0;
  logic [31:0] ld_data = '0, dbg_rdata, retired;
  logic [4:0]  dbg_raddr = '0;
  logic        busy, halted;

  logic        start_b = 1'b0, ld_we_b = 1'b0;
  logic [7:0]  ld_addr_b = '0;
  logic [31:0] ld_data_b = '0, retired_b;
  logic [4:0]  dbg_raddr_b = '0;
  logic [15:0] dbg_rdata_b;
  logic        busy_b, halted_b;

  mips32_pipe_fwd dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_data(ld_data), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
    .busy(busy), .halted(halted), .retired(retired));

  mips32_pipe_fwd #(.XLEN(16), .MEM_DEPTH(256)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .ld_we(ld_we_b), .ld_addr(ld_addr_b),
    .ld_data(ld_data_b), .dbg_raddr(dbg_raddr_b), .dbg_rdata(dbg_rdata_b),
    .busy(busy_b), .halted(halted_b), .retired(retired_b));

  always #5 clk = ~clk;

  int nchk = 0, nerr = 0;

  typedef struct { int tst; logic [4:0] r; logic [31:0] exp; } rvec_t;
  rvec_t tbl [17];

  function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] rd, rs, rt);
    return {op, rs, rt, rd, 11'd0};
  endfunction
  function automatic logic [31:0] ii(input logic [5:0] op, input logic [4:0] rt, rs,
                                     input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr_a(input int addr, input logic [31:0] w);
    @(negedge clk); ld_we = 1'b1; ld_addr = 10'(addr); ld_data = w;
    @(negedge clk); ld_we = 1'b0;
  endtask

  task automatic wr_b(input int addr, input logic [31:0] w);
    @(negedge clk); ld_we_b = 1'b1; ld_addr_b = 8'(addr); ld_data_b = w;
    @(negedge clk); ld_we_b = 1'b0;
  endtask

  task automatic check_regs(input int tst);
    for (int i = 0; i < 17; i++) begin
      if (tbl[i].tst == tst) begin
        dbg_raddr = tbl[i].r; #1;
        check($sformatf("t%0d_r%0d", tst, tbl[i].r), dbg_rdata, tbl[i].exp);
      end
    end
  endtask

  // Pulse start at edge 0, then count edges until halted (bounded)
  task automatic run_a(input bit watch9, output int edges, output int early);
    early = 0;
    if (watch9) dbg_raddr = 5'd9;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    edges = 0;
    while (!halted && edges < 400) begin
      @(posedge clk); #1; edges++;
      if (watch9 && dbg_rdata != 0 && retired < 20) early++;
    end
  endtask

  task automatic load_fact();
    wr_a(0, ii(OP_ADDI, 3, 0, 16'd5));
    wr_a(1, ii(OP_SW, 3, 0, 16'd100));
    wr_a(2, ii(OP_LW, 1, 0, 16'd100));
    wr_a(3, ii(OP_ADDI, 2, 0, 16'd1));
    wr_a(4, ri(OP_MUL, 2, 2, 1));
    wr_a(5, ii(OP_SUBI, 1, 1, 16'd1));
    wr_a(6, ii(OP_BNEQZ, 0, 1, 16'hFFFD));
    wr_a(7, ii(OP_ADDI, 9, 0, 16'd7));
    wr_a(8, {OP_HLT, 26'd0});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int edges, early, nz;
    logic b4;

    tbl[0]  = '{1, 5'd1, 32'd10};   tbl[1]  = '{1, 5'd2, 32'd20};   tbl[2]  = '{1, 5'd3, 32'd30};
    tbl[3]  = '{2, 5'd1, 32'd85};   tbl[4]  = '{2, 5'd2, 32'd85};   tbl[5]  = '{2, 5'd3, 32'd170};
    tbl[6]  = '{3, 5'd1, 32'd0};    tbl[7]  = '{3, 5'd2, 32'd120};  tbl[8]  = '{3, 5'd9, 32'd7};
    tbl[9]  = '{3, 5'd3, 32'd5};    tbl[10] = '{6, 5'd1, 32'd12};   tbl[11] = '{6, 5'd5, 32'h1234};
    tbl[12] = '{6, 5'd6, 32'd0};    tbl[13] = '{7, 5'd1, 32'd24};   tbl[14] = '{7, 5'd5, 32'h1234};
    tbl[15] = '{4, 5'd2, 32'd120};  tbl[16] = '{4, 5'd1, 32'd0};

    #12 rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_retired", retired, 0);
    dbg_raddr = 5'd5; #1;
    check("rst_r5", dbg_rdata, 0);

    // Test 1: back-to-back forwarding
    wr_a(0, ii(OP_ADDI, 1, 0, 16'd10));
    wr_a(1, ii(OP_ADDI, 2, 0, 16'd20));
    wr_a(2, ri(OP_ADD, 3, 1, 2));
    wr_a(3, {OP_HLT, 26'd0});
    run_a(1'b0, edges, early);
    check("t1_edges", 32'(edges), 8);
    check("t1_busy", 32'(busy), 0);
    check("t1_retired", retired, 3);
    check_regs(1);

    // Test 2: store, load, load-use stall
    wr_a(0, ii(OP_ADDI, 1, 0, 16'd85));
    wr_a(1, ii(OP_SW, 1, 0, 16'd200));
    wr_a(2, ii(OP_LW, 2, 0, 16'd200));
    wr_a(3, ri(OP_ADD, 3, 2, 2));
    wr_a(4, {OP_HLT, 26'd0});
    run_a(1'b0, edges, early);
    check("t2_edges", 32'(edges), 10);
    check("t2_retired", retired, 4);
    check_regs(2);

    // Test 3: factorial loop with four taken branches
    load_fact();
    run_a(1'b1, edges, early);
    check("t3_edges", 32'(edges), 33);
    check("t3_retired", retired, 20);
    check("t3_r9_early", 32'(early), 0);
    check_regs(3);

    // Test 4: asynchronous reset mid-loop, then reload and rerun
    load_fact();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (15) @(posedge clk);
    #2; b4 = busy;
    rst_n = 1'b0; #1;
    check("t4_busy_before", 32'(b4), 1);
    check("t4_busy", 32'(busy), 0);
    check("t4_halted", 32'(halted), 0);
    check("t4_retired", retired, 0);
    nz = 0;
    for (int r = 0; r < 32; r++) begin
      dbg_raddr = 5'(r); #1;
      if (dbg_rdata != 0) nz++;
    end
    check("t4_regs_nonzero", 32'(nz), 0);
    @(negedge clk); rst_n = 1'b1;
    load_fact();
    run_a(1'b0, edges, early);
    check("t4_edges", 32'(edges), 33);
    check("t4_retired2", retired, 20);
    check_regs(4);

    // Test 6: ld_we and start ignored in RUN, unknown opcode halts, rerun keeps registers
    wr_a(60, 32'h1234);
    wr_a(0, ii(OP_ADDI, 1, 0, 16'd3));
    wr_a(1, ii(OP_ADDI, 1, 1, 16'd4));
    wr_a(2, ii(OP_ADDI, 1, 1, 16'd5));
    wr_a(3, ii(OP_LW, 5, 0, 16'd60));
    wr_a(4, 32'hE800_0000);
    wr_a(5, ii(OP_ADDI, 6, 0, 16'd99));
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk); ld_we = 1'b1; ld_addr = 10'd60; ld_data = 32'hDEAD; start = 1'b1;
    @(posedge clk); #1; ld_we = 1'b0; start = 1'b0;
    edges = 1;
    while (!halted && edges < 400) begin
      @(posedge clk); #1; edges++;
    end
    check("t6_edges", 32'(edges), 9);
    check("t6_retired", retired, 4);
    check_regs(6);
    wr_a(0, ii(OP_ADDI, 1, 1, 16'd3));
    check("t6_halted_hold", 32'(halted), 1);
    run_a(1'b0, edges, early);
    check("t7_edges", 32'(edges), 9);
    check("t7_retired", retired, 4);
    check_regs(7);

    // Test 5: 16-bit datapath wraparound and signed compare
    wr_b(0, ii(OP_ADDI, 1, 0, 16'h7FFF));
    wr_b(1, ii(OP_ADDI, 1, 1, 16'd1));
    wr_b(2, ii(OP_SLTI, 2, 1, 16'd0));
    wr_b(3, {OP_HLT, 26'd0});
    @(negedge clk); start_b = 1'b1;
    @(posedge clk); #1; start_b = 1'b0;
    edges = 0;
    while (!halted_b && edges < 400) begin
      @(posedge clk); #1; edges++;
    end
    check("t5_edges", 32'(edges), 8);
    check("t5_retired", retired_b, 3);
    dbg_raddr_b = 5'd1; #1;
    check("t5_r1", 32'(dbg_rdata_b), 32'h8000);
    dbg_raddr_b = 5'd2; #1;
    check("t5_r2", 32'(dbg_rdata_b), 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
